// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM1RW request controller: state encoding and the
// idle (deselected) levels of the macro control pins.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    localparam logic CSB_IDLE = 1'b1;
    localparam logic WEB_IDLE = 1'b1;
    localparam logic OEB_IDLE = 1'b1;
    localparam logic CE_IDLE  = 1'b0;

endpackage

// File: rtl/sram1rw_req_ctrl.sv
// Valid/ready request front-end for one SRAM1RW macro; every pin comes from a flop.
// Build option SRAM_CTRL_WR_RESP_EN: writes also return a response (resp_is_write=1).
//
// state   | meaning
// IDLE    | macro deselected, waiting for a request
// SETUP   | CSB low, A/WEB/I launched, CE low
// STROBE  | CE high for one cycle, macro samples on its rising edge
// CAPTURE | read only: OEB low, sram_O captured into resp_rdata
// RESP    | response held until resp_ready
module sram1rw_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_is_write,
    output logic [ADDR_W-1:0] sram_A,
    output logic              sram_CE,
    output logic              sram_WEB,
    output logic              sram_OEB,
    output logic              sram_CSB,
    output logic [DATA_W-1:0] sram_I,
    input  logic [DATA_W-1:0] sram_O
);

    state_t state, next_state;

    logic              ready_d, valid_d, ce_d, csb_d, oeb_d, web_d;
    logic [ADDR_W-1:0] a_d;
    logic [DATA_W-1:0] i_d, rdata_d;
    logic              accept;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // sram_WEB still holds the operation type of the access in flight
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (req_valid && req_ready) next_state = ST_SETUP;
            ST_SETUP:   next_state = ST_STROBE;
            ST_STROBE: begin
                if (sram_WEB) next_state = ST_CAPTURE;
`ifdef SRAM_CTRL_WR_RESP_EN
                else          next_state = ST_RESP;
`else
                else          next_state = ST_IDLE;
`endif
            end
            ST_CAPTURE: next_state = ST_RESP;
            ST_RESP:    if (resp_ready) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Pin values are decoded from next_state so the flops present them in that state.
    // A/WEB/I load only on accept and are otherwise held, so they never move around CE.
    always_comb begin
        accept  = (state == ST_IDLE) && (next_state == ST_SETUP);
        ready_d = (next_state == ST_IDLE);
        valid_d = (next_state == ST_RESP);
        ce_d    = (next_state == ST_STROBE) ? 1'b1 : CE_IDLE;
        oeb_d   = (next_state == ST_CAPTURE) ? 1'b0 : OEB_IDLE;
        csb_d   = (next_state == ST_SETUP || next_state == ST_STROBE ||
                   next_state == ST_CAPTURE) ? 1'b0 : CSB_IDLE;
        a_d     = accept ? req_addr   : sram_A;
        web_d   = accept ? ~req_write : sram_WEB;
        i_d     = accept ? req_wdata  : sram_I;
        rdata_d = resp_rdata;
        if (state == ST_CAPTURE)
            rdata_d = sram_O;
        else if (state == ST_STROBE && next_state == ST_RESP)
            rdata_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            sram_A     <= '0;
            sram_CE    <= CE_IDLE;
            sram_WEB   <= WEB_IDLE;
            sram_OEB   <= OEB_IDLE;
            sram_CSB   <= CSB_IDLE;
            sram_I     <= '0;
        end else begin
            req_ready  <= ready_d;
            resp_valid <= valid_d;
            resp_rdata <= rdata_d;
            sram_A     <= a_d;
            sram_CE    <= ce_d;
            sram_WEB   <= web_d;
            sram_OEB   <= oeb_d;
            sram_CSB   <= csb_d;
            sram_I     <= i_d;
        end
    end

`ifdef SRAM_CTRL_WR_RESP_EN
    always_ff @(posedge clock) begin
        if (reset) resp_is_write <= 1'b0;
        else       resp_is_write <= (next_state == ST_RESP) && !sram_WEB;
    end
`else
    assign resp_is_write = 1'b0;
`endif

endmodule
